// File: rtl/eth_rx.sv
// RMII receive front end: dibit assembly, preamble/SFD hunt, CRC-32 residue check
// and a 5-byte delay line that strips the FCS before bytes reach the consumer.
module eth_rx #(
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  logic        eth_crsdv,
    input  logic [1:0]  eth_rxd,
    output logic        rx_vld,
    output logic [7:0]  rx_dat,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [10:0] rx_len
);
    localparam logic [2:0]  S_SYNC  = 3'd0;
    localparam logic [2:0]  S_IDLE  = 3'd1;
    localparam logic [2:0]  S_PRE   = 3'd2;
    localparam logic [2:0]  S_DATA  = 3'd3;
    localparam logic [2:0]  S_DROP  = 3'd4;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MAX_LEN_W   = 11'(MAX_LEN);

    logic [2:0]  r_state;
    logic        r_crs_q;
    logic [1:0]  r_pend_d;
    logic [7:0]  r_sh;
    logic [1:0]  r_idx;
    logic [7:0]  r_fifo [0:4];
    logic [2:0]  r_cnt;
    logic [10:0] r_bytes;
    logic [31:0] r_crc;
    logic        r_first;

    logic        w_eoc;
    logic        w_bad;
    logic        w_done;
    logic [7:0]  w_byte;
    logic [7:0]  w_sh;
    logic [1:0]  w_idx;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign w_eoc = !eth_crsdv && !r_crs_q;
    assign w_bad = (r_crc != CRC_RESIDUE) || (r_bytes < 11'd64) ||
                   (r_bytes > MAX_LEN_W) || (r_idx != 2'd0);

    // A low CRS_DV sample is held back one clock: if the carrier returns, that
    // dibit is folded in together with the current one; if not, it is dropped.
    always_comb begin
        w_sh   = r_sh;
        w_idx  = r_idx;
        w_done = 1'b0;
        w_byte = 8'h00;
        if (r_state == S_DATA && eth_crsdv) begin
            if (!r_crs_q) begin
                w_sh = {r_pend_d, w_sh[7:2]};
                if (w_idx == 2'd3) begin
                    w_done = 1'b1;
                    w_byte = w_sh;
                end
                w_idx = w_idx + 2'd1;
            end
            w_sh = {eth_rxd, w_sh[7:2]};
            if (w_idx == 2'd3) begin
                w_done = 1'b1;
                w_byte = w_sh;
            end
            w_idx = w_idx + 2'd1;
        end
    end

    always_ff @(posedge clk_mac) begin
        r_pend_d <= eth_rxd;
        if (rst) begin
            r_state <= S_SYNC;
            r_crs_q <= 1'b1;
            r_idx   <= 2'd0;
            r_cnt   <= 3'd0;
            r_bytes <= 11'd0;
            r_crc   <= 32'hFFFFFFFF;
            r_first <= 1'b0;
            rx_vld  <= 1'b0;
            rx_dat  <= 8'h00;
            rx_sof  <= 1'b0;
            rx_eof  <= 1'b0;
            rx_err  <= 1'b0;
            rx_len  <= 11'd0;
        end else begin
            r_crs_q <= eth_crsdv;
            rx_vld  <= 1'b0;
            rx_sof  <= 1'b0;
            rx_eof  <= 1'b0;
            rx_err  <= 1'b0;
            rx_len  <= 11'd0;
            case (r_state)
                S_SYNC, S_DROP: if (w_eoc) r_state <= S_IDLE;
                S_IDLE: begin
                    if (eth_crsdv && eth_rxd == 2'b01) begin
                        r_state <= S_PRE;
                        r_crc   <= 32'hFFFFFFFF;
                        r_bytes <= 11'd0;
                        r_cnt   <= 3'd0;
                        r_idx   <= 2'd0;
                    end
                end
                S_PRE: begin
                    if (w_eoc) begin
                        r_state <= S_IDLE;
                    end else if (eth_crsdv) begin
                        if (eth_rxd == 2'b11) begin
                            r_state <= S_DATA;
                            r_idx   <= 2'd0;
                            r_first <= 1'b1;
                        end else if (eth_rxd == 2'b10) begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_DATA: begin
                    if (w_eoc) begin
                        // The four bytes still behind the oldest one are the FCS.
                        if (r_cnt == 3'd5) begin
                            rx_vld <= 1'b1;
                            rx_dat <= r_fifo[0];
                            rx_sof <= r_first;
                            rx_eof <= 1'b1;
                            rx_err <= w_bad;
                            rx_len <= r_bytes - 11'd4;
                        end
                        r_cnt   <= 3'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_sh  <= w_sh;
                        r_idx <= w_idx;
                        if (w_done) begin
                            r_crc <= crc_byte(r_crc, w_byte);
                            if (r_bytes != 11'h7FF) r_bytes <= r_bytes + 11'd1;
                            if (r_cnt == 3'd5) begin
                                rx_vld    <= 1'b1;
                                rx_dat    <= r_fifo[0];
                                rx_sof    <= r_first;
                                r_first   <= 1'b0;
                                r_fifo[0] <= r_fifo[1];
                                r_fifo[1] <= r_fifo[2];
                                r_fifo[2] <= r_fifo[3];
                                r_fifo[3] <= r_fifo[4];
                                r_fifo[4] <= w_byte;
                            end else begin
                                r_fifo[r_cnt] <= w_byte;
                                r_cnt         <= r_cnt + 3'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx.sv
// Randomized bench for eth_rx: frames are built with a real FCS, the expected
// strobe stream is derived from the frame contents and compared on the falling edge.
module tb_eth_rx;
    logic        clk_mac = 1'b0;
    logic        rst = 1'b1;
    logic        eth_crsdv = 1'b0;
    logic [1:0]  eth_rxd = 2'b00;
    logic        rx_vld, rx_sof, rx_eof, rx_err;
    logic [7:0]  rx_dat;
    logic [10:0] rx_len;

    eth_rx #(.MAX_LEN(1518)) dut (
        .clk_mac(clk_mac), .rst(rst), .eth_crsdv(eth_crsdv), .eth_rxd(eth_rxd),
        .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_err(rx_err), .rx_len(rx_len)
    );

    always #10 clk_mac = ~clk_mac;

    typedef struct {
        logic [7:0]  dat;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_cur;
    logic [7:0] frm[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int n, input int rnd);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(rnd != 0 ? 8'($urandom) : 8'(i));
        f = fcs_of(n);
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    // Whole-frame rule: everything but the last four bytes is delivered in order.
    task automatic expect_frame(input int extra);
        int n;
        logic [31:0] rx_fcs;
        logic bad;
        exp_t e;
        n = frm.size();
        if (n < 5) return;
        rx_fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
        bad = (fcs_of(n-4) != rx_fcs) || (n < 64) || (n > 1518) || (extra != 0);
        for (int k = 0; k <= n-5; k++) begin
            e.dat = frm[k];
            e.sof = (k == 0);
            e.eof = (k == n-5);
            e.err = e.eof ? bad : 1'b0;
            e.len = e.eof ? 11'(((n > 2047) ? 2047 : n) - 4) : 11'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic crs, input logic [1:0] d);
        @(negedge clk_mac);
        eth_crsdv = crs;
        eth_rxd   = d;
    endtask

    task automatic gap(input string tag);
        repeat (12) drive(1'b0, 2'b00);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic send_frame(input int toggle, input int extra, input int rst_at);
        int nd;
        int rem;
        logic [7:0] bv;
        logic [1:0] d;
        logic crs;
        logic rst_rel;
        rst_rel = 1'b0;
        for (int p = 0; p < 8; p++)
            for (int q = 0; q < 4; q++)
                drive(1'b1, (p == 7 && q == 3) ? 2'b11 : 2'b01);
        nd = frm.size() * 4 + extra;
        for (int j = 0; j < nd; j++) begin
            rem = nd - 1 - j;
            if (j / 4 < frm.size()) begin
                bv = frm[j/4];
                d = bv[2*(j%4) +: 2];
            end else begin
                d = 2'b10;
            end
            crs = (toggle != 0 && rem < 8) ? (rem % 2 == 0) : 1'b1;
            drive(crs, d);
            if (rst_rel) begin
                rst = 1'b0;
                rst_rel = 1'b0;
            end
            if (rst_at >= 0 && j == rst_at * 4) begin
                rst = 1'b1;
                @(posedge clk_mac);
                #1;
                exp_q.delete();
                check("rst_pulse_vld", rx_vld, 0);
                check("rst_pulse_eof", rx_eof, 0);
                rst_rel = 1'b1;
            end
        end
    endtask

    always @(posedge clk_mac) cyc <= cyc + 1;

    always @(negedge clk_mac) begin
        if (rx_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {24'h0, rx_dat}, 32'hFFFF_FFFF);
            end else begin
                e_cur = exp_q.pop_front();
                check("dat", rx_dat, e_cur.dat);
                check("sof", rx_sof, e_cur.sof);
                check("eof", rx_eof, e_cur.eof);
                check("err", rx_err, e_cur.err);
                check("len", rx_len, e_cur.len);
                if (!rx_sof && !rx_eof) check("spacing", cyc - last_cyc, 4);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk_mac);
        check("reset_vld", rx_vld, 0);
        check("reset_sof", rx_sof, 0);
        check("reset_eof", rx_eof, 0);
        check("reset_err", rx_err, 0);
        check("reset_len", rx_len, 0);
        check("reset_dat", rx_dat, 0);
        rst = 1'b0;
        repeat (4) drive(1'b0, 2'b00);

        build(60, 0); expect_frame(0); send_frame(0, 0, -1); gap("frame64_drain");
        build(60, 0); frm[10] = frm[10] ^ 8'h01; expect_frame(0); send_frame(0, 0, -1);
        gap("crc_bad_drain");
        build(36, 0); expect_frame(0); send_frame(0, 0, -1); gap("short40_drain");
        build(1515, 1); expect_frame(0); send_frame(0, 0, -1); gap("long1519_drain");
        build(60, 1); expect_frame(0); send_frame(1, 0, -1); gap("toggle_drain");

        for (int i = 0; i < 20; i++) drive(1'b1, 2'b01);
        gap("preamble_only");
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b10);
        for (int i = 0; i < 40; i++) drive(1'b1, 2'($urandom));
        gap("drop_frame");

        frm.delete();
        for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
        send_frame(0, 0, -1); gap("tiny_frame");
        build(1, 1); expect_frame(0); send_frame(0, 0, -1); gap("five_byte");

        build(60, 1); expect_frame(0); send_frame(0, 0, 30); gap("reset_mid_frame");
        build(60, 1); expect_frame(0); send_frame(0, 0, -1); gap("after_reset");
        build(60, 0); expect_frame(1); send_frame(0, 1, -1); gap("dribble");

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 120);
            build(n, 1);
            if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, n - 1)] ^= 8'h80;
            expect_frame(0);
            send_frame($urandom_range(0, 1), 0, -1);
            gap("random_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
